// File: rtl/fifo_lvl.sv
// fifo_lvl: synchronous first-word-fall-through FIFO for any DEPTH >= 2, with
// occupancy count, programmable almost flags, sticky error flags and optional flush.
module fifo_lvl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter     CLEAR = "none",
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             w,
  input  logic             r,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] af_th,
  input  logic [CNT_W-1:0] ae_th,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic             clr,
  output logic             ovf,
  output logic             udf,
  input  logic             err_clr
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam bit FLUSH_EN = (CLEAR == "sync");

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count_nxt;
  logic             rd_acc, wr_acc, flush;
  logic             ovf_set, udf_set;

  // w and r are request strobes, not a valid/ready pair: a read is accepted
  // when the FIFO is not empty; a write when it is not full, or when a read
  // frees a slot in the same cycle. Rejected requests raise ovf/udf instead.
  assign rd_acc = r & ~empty;
  assign wr_acc = w & (~full | r);
  assign flush  = FLUSH_EN & clr;

  assign ovf_set = ~flush & w & ~wr_acc;
  assign udf_set = ~flush & r & empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wptr  <= rptr;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_acc) wptr <= ptr_inc(wptr);
      if (rd_acc) rptr <= ptr_inc(rptr);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // A set event outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end

  assign dout         = mem[rptr];
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench for fifo_lvl: two DEPTH=5 instances (CLEAR="sync" and "none")
// share one stimulus stream; outputs are compared against hand-computed vectors.
module tb_fifo_lvl;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rstn, w, r, clr, err_clr;
  logic [W-1:0]  din;
  logic [CW-1:0] af_th, ae_th;

  logic [W-1:0]  s_dout, n_dout;
  logic [CW-1:0] s_count, n_count;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          n_full, n_empty, n_af, n_ae, n_ovf, n_udf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_lvl #(.WIDTH(W), .DEPTH(D), .CLEAR("sync")) dut_s (
    .clk(clk), .rstn(rstn), .din(din), .w(w), .r(r), .dout(s_dout),
    .full(s_full), .empty(s_empty), .count(s_count), .af_th(af_th), .ae_th(ae_th),
    .almost_full(s_af), .almost_empty(s_ae), .clr(clr), .ovf(s_ovf), .udf(s_udf),
    .err_clr(err_clr)
  );

  fifo_lvl #(.WIDTH(W), .DEPTH(D), .CLEAR("none")) dut_n (
    .clk(clk), .rstn(rstn), .din(din), .w(w), .r(r), .dout(n_dout),
    .full(n_full), .empty(n_empty), .count(n_count), .af_th(af_th), .ae_th(ae_th),
    .almost_full(n_af), .almost_empty(n_ae), .clr(clr), .ovf(n_ovf), .udf(n_udf),
    .err_clr(err_clr)
  );

  typedef struct packed {
    logic          w, r, clr, ec;
    logic [W-1:0]  din;
    logic [CW-1:0] af, ae;
    logic [CW-1:0] cnt;
    logic          chk_dout;
    logic [W-1:0]  dout;
    logic          full, empty, ovf, udf, af_o, ae_o;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input int cnt, input bit e_full, input bit e_empty,
                            input bit e_ovf, input bit e_udf, input bit e_af, input bit e_ae,
                            input bit chk_dout, input int e_dout);
    chk({tag, ".s.count"}, 32'(s_count), 32'(cnt));
    chk({tag, ".n.count"}, 32'(n_count), 32'(cnt));
    chk({tag, ".s.full"},  32'(s_full),  32'(e_full));
    chk({tag, ".n.full"},  32'(n_full),  32'(e_full));
    chk({tag, ".s.empty"}, 32'(s_empty), 32'(e_empty));
    chk({tag, ".n.empty"}, 32'(n_empty), 32'(e_empty));
    chk({tag, ".s.ovf"},   32'(s_ovf),   32'(e_ovf));
    chk({tag, ".n.ovf"},   32'(n_ovf),   32'(e_ovf));
    chk({tag, ".s.udf"},   32'(s_udf),   32'(e_udf));
    chk({tag, ".n.udf"},   32'(n_udf),   32'(e_udf));
    chk({tag, ".s.af"},    32'(s_af),    32'(e_af));
    chk({tag, ".n.af"},    32'(n_af),    32'(e_af));
    chk({tag, ".s.ae"},    32'(s_ae),    32'(e_ae));
    chk({tag, ".n.ae"},    32'(n_ae),    32'(e_ae));
    if (chk_dout) begin
      chk({tag, ".s.dout"}, 32'(s_dout), 32'(e_dout));
      chk({tag, ".n.dout"}, 32'(n_dout), 32'(e_dout));
    end
  endtask

  // Drive one cycle of requests, then sample just after the edge.
  task automatic step(input logic w_i, input logic r_i, input logic clr_i,
                      input logic ec_i, input logic [W-1:0] d_i);
    w       = w_i;
    r       = r_i;
    clr     = clr_i;
    err_clr = ec_i;
    din     = d_i;
    @(posedge clk);
    #1;
    w       = 1'b0;
    r       = 1'b0;
    clr     = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    //             w     r     clr   ec    din    af    ae    cnt   chk   dout   full  empty ovf   udf   af_o  ae_o
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 3'd4, 3'd1, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 3'd4, 3'd1, 3'd2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 3'd4, 3'd1, 3'd3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 3'd4, 3'd1, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 3'd4, 3'd1, 3'd5, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 3'd4, 3'd1, 3'd5, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 3'd1, 3'd5, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 3'd4, 3'd1, 3'd5, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd4, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd3, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd2, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 3'd4, 3'd1, 3'd1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd4, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0; w = 1'b0; r = 1'b0; clr = 1'b0; err_clr = 1'b0; din = '0;
    af_th = 3'd4; ae_th = 3'd1;

    // Reset state, then dirty the FIFO and pull reset asynchronously mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 0, 0, 1, 0, 0, 0, 1, 0, 0);
    #2 rstn = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hE1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hE2);
    check_both("pre_rst", 2, 0, 0, 0, 1, 0, 0, 1, 8'hE1);
    #2 rstn = 1'b0;
    #1 check_both("async_rst", 0, 0, 1, 0, 0, 0, 1, 0, 0);
    #2 rstn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      af_th = vecs[i].af;
      ae_th = vecs[i].ae;
      step(vecs[i].w, vecs[i].r, vecs[i].clr, vecs[i].ec, vecs[i].din);
      check_both($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].full, vecs[i].empty,
                 vecs[i].ovf, vecs[i].udf, vecs[i].af_o, vecs[i].ae_o,
                 vecs[i].chk_dout, int'(vecs[i].dout));
    end

    // Fill, overflow, drain three times so the pointers wrap at different offsets.
    af_th = 3'd4;
    ae_th = 3'd1;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 1; i <= D; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'(pass * 16 + i));
        check_both($sformatf("fill%0d_%0d", pass, i), i, (i == D), 0, 0, 0,
                   (i >= 4), (i <= 1), 1, pass * 16 + 1);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
      check_both($sformatf("ovf%0d", pass), D, 1, 0, 1, 0, 1, 0, 1, pass * 16 + 1);
      if (pass == 0) begin
        af_th = 3'd6;
        #1;
        chk("af_th6.s", 32'(s_af), 32'd0);
        chk("af_th6.n", 32'(n_af), 32'd0);
        af_th = 3'd4;
        #1;
        chk("af_th4.s", 32'(s_af), 32'd1);
        chk("af_th4.n", 32'(n_af), 32'd1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("ovf_clr%0d", pass), 32'(s_ovf), 32'd0);
      for (int i = 1; i <= D; i++) begin
        chk($sformatf("drain%0d_%0d.s", pass, i), 32'(s_dout), 32'(pass * 16 + i));
        chk($sformatf("drain%0d_%0d.n", pass, i), 32'(n_dout), 32'(pass * 16 + i));
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk($sformatf("drain_cnt%0d_%0d", pass, i), 32'(s_count), 32'(D - i));
      end
      check_both($sformatf("drained%0d", pass), 0, 0, 1, 0, 0, 0, 1, 0, 0);
    end

    // Flush with a simultaneous write: honoured only by the CLEAR="sync" instance.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
    check_both("pre_flush", 3, 0, 0, 0, 0, 0, 0, 1, 8'hC1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hC4);
    chk("flush.s.count", 32'(s_count), 32'd0);
    chk("flush.s.empty", 32'(s_empty), 32'd1);
    chk("flush.n.count", 32'(n_count), 32'd4);
    chk("flush.n.dout",  32'(n_dout),  32'hC1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hD7);
    chk("post_flush.s.count", 32'(s_count), 32'd1);
    chk("post_flush.s.dout",  32'(s_dout),  32'hD7);
    chk("post_flush.s.empty", 32'(s_empty), 32'd0);
    chk("post_flush.n.count", 32'(n_count), 32'd5);
    chk("post_flush.n.full",  32'(n_full),  32'd1);
    chk("post_flush.n.dout",  32'(n_dout),  32'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
- Next-generation fully synchronous, first-word-fall-through FIFO for MCU peripherals (UART/SPI buffers, DMA staging).
- Generalises depth to any integer ≥2, not only powers of two.
- Adds an occupancy count output and run-time programmable almost-full / almost-empty thresholds.
- Adds sticky overflow/underflow error flags and an optional synchronous flush.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; any integer ≥2.
- CLEAR, "none", "none" or "sync"; "none" ties the internal flush to 0 and ignores clr.
- CNT_W, $clog2(DEPTH+1), width of count and threshold ports; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rstn  in  1  reset, asynchronous, active-low
- din  in  WIDTH  write data
- w  in  1  write request
- r  in  1  read request; pops the word currently shown on dout
- dout  out  WIDTH  head-of-queue word; valid whenever empty=0
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  CNT_W  current occupancy, 0..DEPTH
- af_th  in  CNT_W  almost-full threshold
- ae_th  in  CNT_W  almost-empty threshold
- almost_full  out  1  count ≥ af_th
- almost_empty  out  1  count ≤ ae_th
- clr  in  1  synchronous flush; ignored when CLEAR="none"
- ovf  out  1  sticky: write rejected
- udf  out  1  sticky: read rejected
- err_clr  in  1  synchronous clear of ovf/udf

Behaviour:
- Clock is clk. Reset is rstn, asynchronous and active-low.
- Reset (rstn=0, asynchronous): wptr=0, rptr=0, count=0, full=0, empty=1, ovf=0, udf=0. almost_full and almost_empty follow from count and the thresholds. Storage array is not reset.
- Reset mid-operation discards all contents. The first write after rstn rises is read back first.
- Read acceptance: rd_acc = r & ~empty.
- Write acceptance: wr_acc = w & (~full | r). A write is accepted while full only if a read happens in the same cycle.
- Storage and pointers:
  - wr_acc writes din to array[wptr].
  - wptr advances on wr_acc, rptr advances on rd_acc.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, never by binary overflow.
- dout = array[rptr], combinational. Content is undefined when empty=1.
- Write-to-read latency: 1 cycle. A word written at edge N appears on dout after edge N with empty=0.
- Count update per edge:
  - wr_acc & ~rd_acc: +1
  - rd_acc & ~wr_acc: -1
  - both: unchanged, with data shifted through
  - neither: unchanged
- full and empty are registered and must match count every cycle.
- Empty with w=1, r=1: the read is rejected (udf sets), the write is accepted, count becomes 1.
- almost_full and almost_empty are combinational compares on the registered count. The compare is unsigned.
  - af_th=0: almost_full is always 1.
  - af_th>DEPTH: almost_full is never 1.
- Error flags:
  - ovf sets when w & ~wr_acc.
  - udf sets when r & empty.
  - Both hold until err_clr or reset.
  - A set event and err_clr in the same cycle: set wins, so the flag reads 1.
- Flush (CLEAR="sync", clr=1): highest priority after reset.
  - wptr<=rptr, count<=0, empty<=1, full<=0.
  - w and r are ignored that cycle; ovf and udf do not change from w/r that cycle.
  - err_clr is still honoured in a flush cycle.
- Priority order: rstn > clr > normal push/pop. err_clr is independent of this order.
- Threshold ports may change at any time; the almost flags follow combinationally.

Test Plan:
- Reset and basic flow (WIDTH=8, DEPTH=5): assert rstn=0 asynchronously mid-cycle → empty=1, count=0, ovf=0 immediately. Release, write 0x11 → next cycle dout=0x11, empty=0, count=1.
- Fill and wrap (DEPTH=5): write 0x01..0x05 → full=1, count=5. Write 0x06 → rejected, ovf=1, count stays 5. Read 5 words → dout sequence 0x01..0x05, empty=1. Repeat 3 times → wrap-around correct every pass.
- Simultaneous ops:
  - Full with w=r=1, din=0xAA → count stays 5, ovf=0, 0xAA appears last.
  - Empty with w=r=1, din=0x55 → udf=1, count=1, dout=0x55.
- Thresholds: af_th=4, ae_th=1, fill 0→5 → almost_empty=1 at counts 0,1. almost_full=1 at counts 4,5. Change af_th to 6 at count 5 → almost_full=0 the same cycle.
- Flush (CLEAR="sync"): at count=3, pulse clr with w=1 → count=0, empty=1, write ignored. With CLEAR="none", the same stimulus → count=4.
- Error clear: set udf, then pulse err_clr → udf=0. Pulse err_clr together with a rejected read → udf stays 1.
